// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table extractor.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    localparam int TT_SETTLE_CYC_DEF = 1;

    function automatic int tt_mask_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that stops at zero and flags it.
// Latency: zero reflects the count in the cycle after load; no backpressure.
module tt_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all input vectors onto a combinational circuit and assembles its minterm mask.
// Latency: done pulses 2**N_IN*(SETTLE_CYC+1) edges after start; start is ignored while busy/done.
// Optional TT_MISMATCH_STOP_EN: stop at the first vector disagreeing with the expected mask.
module truth_table_extractor
    import tt_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = TT_SETTLE_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [tt_mask_w(N_IN)-1:0] expected,
    output logic [N_IN-1:0]            vec_out,
    input  logic                       resp_in,
    output logic                       busy,
    output logic                       done,
    output logic [tt_mask_w(N_IN)-1:0] minterms,
    output logic                       match
`ifdef TT_MISMATCH_STOP_EN
    ,
    output logic                       fail,
    output logic [N_IN-1:0]            fail_idx
`endif
);

    localparam int MW = tt_mask_w(N_IN);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);

    tt_state_t      state;
    logic [MW-1:0]  expected_q;
    logic [MW-1:0]  mask_next;
    logic           last_vec;
    logic           stop_now;
    logic           timer_load;
    logic           timer_zero;

    assign last_vec = &vec_out;

`ifdef TT_MISMATCH_STOP_EN
    assign stop_now = (resp_in != expected_q[vec_out]);
`else
    assign stop_now = 1'b0;
`endif

    // The final sample is folded in here so match is valid in the done cycle itself.
    always_comb begin
        mask_next          = minterms;
        mask_next[vec_out] = resp_in;
    end

    assign timer_load = ((state == IDLE) && start) ||
                        ((state == SAMPLE) && !last_vec && !stop_now);

    tt_settle_timer #(
        .W(CW)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            minterms   <= '0;
            match      <= 1'b0;
            expected_q <= '0;
`ifdef TT_MISMATCH_STOP_EN
            fail       <= 1'b0;
            fail_idx   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_out    <= '0;
                        minterms   <= '0;
                        expected_q <= expected;
                        busy       <= 1'b1;
                        state      <= SETTLE;
`ifdef TT_MISMATCH_STOP_EN
                        fail       <= 1'b0;
                        fail_idx   <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (timer_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    minterms <= mask_next;
                    if (last_vec || stop_now) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        match <= !stop_now && (mask_next == expected_q);
`ifdef TT_MISMATCH_STOP_EN
                        if (stop_now) begin
                            fail     <= 1'b1;
                            fail_idx <= vec_out;
                        end
`endif
                    end else begin
                        vec_out <= vec_out + VEC_ONE;
                        state   <= SETTLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench for truth_table_extractor: default instance plus an N_IN=2, SETTLE_CYC=3 instance.
module tb_truth_table_extractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    // Default instance
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic [2:0] vec_out;
    logic       resp;
    logic       busy;
    logic       done;
    logic [7:0] minterms;
    logic       match;
`ifdef TT_MISMATCH_STOP_EN
    logic       fail;
    logic [2:0] fail_idx;
`endif

    // Small instance
    logic       start2 = 1'b0;
    logic [3:0] expected2 = 4'h0;
    logic [1:0] vec2;
    logic       resp2;
    logic       busy2;
    logic       done2;
    logic [3:0] minterms2;
    logic       match2;
`ifdef TT_MISMATCH_STOP_EN
    logic       fail2;
    logic [1:0] fail_idx2;
`endif

    // Circuits under test: f = sum m(0,2,4,6,7) and f = a & b
    logic [7:0] f_mask = 8'hD5;
    assign resp  = f_mask[vec_out];
    assign resp2 = &vec2;

    truth_table_extractor u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .expected (expected),
        .vec_out  (vec_out),
        .resp_in  (resp),
        .busy     (busy),
        .done     (done),
        .minterms (minterms),
        .match    (match)
`ifdef TT_MISMATCH_STOP_EN
        ,
        .fail     (fail),
        .fail_idx (fail_idx)
`endif
    );

    truth_table_extractor #(
        .N_IN       (2),
        .SETTLE_CYC (3)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .expected (expected2),
        .vec_out  (vec2),
        .resp_in  (resp2),
        .busy     (busy2),
        .done     (done2),
        .minterms (minterms2),
        .match    (match2)
`ifdef TT_MISMATCH_STOP_EN
        ,
        .fail     (fail2),
        .fail_idx (fail_idx2)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] mask;
        logic       match;
        int         done_cyc;
        logic       fail;
        logic [2:0] fail_idx;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after the posedge that makes cyc == c.
    task automatic at_edge(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_sweep(input bit second, output int acc);
        @(negedge clk);
        if (second) start2 = 1'b1;
        else        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
        acc = cyc;
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (done) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: done high at cycle %0d, none expected", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("minterms", 32'(minterms), 32'(e1.mask));
                chk("match", 32'(match), 32'(e1.match));
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("done_cycle", cyc, e1.done_cyc);
`ifdef TT_MISMATCH_STOP_EN
                chk("fail", 32'(fail), 32'(e1.fail));
                chk("fail_idx", 32'(fail_idx), 32'(e1.fail_idx));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done2_unexpected: done2 high at cycle %0d, none expected", cyc);
            end else begin
                e2 = q2.pop_front();
                chk("minterms2", 32'(minterms2), 32'(e2.mask));
                chk("match2", 32'(match2), 32'(e2.match));
                chk("busy2_in_done", 32'(busy2), 32'd0);
                chk("done2_cycle", cyc, e2.done_cyc);
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int acc2;

        // Reset state
        #12;
        chk("rst_vec_out", 32'(vec_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_minterms", 32'(minterms), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Matching sweep with per-edge vector stepping
        expected = 8'hD5;
        start_sweep(1'b0, acc);
        q1.push_back('{8'hD5, 1'b1, acc + 16, 1'b0, 3'd0});
        for (int k = 0; k <= 16; k++) begin
            at_edge(acc + k);
            chk("vec_step", 32'(vec_out), (k / 2 > 7) ? 32'd7 : 32'(k / 2));
            chk("busy_sweep", 32'(busy), (k < 16) ? 32'd1 : 32'd0);
        end
        at_edge(acc + 18);
        chk("idle_vec_hold", 32'(vec_out), 32'd7);
        chk("idle_busy", 32'(busy), 32'd0);

        // Mismatching expected mask
        expected = 8'hD4;
        start_sweep(1'b0, acc);
`ifdef TT_MISMATCH_STOP_EN
        q1.push_back('{8'h01, 1'b0, acc + 2, 1'b1, 3'd0});
`else
        q1.push_back('{8'hD5, 1'b0, acc + 16, 1'b0, 3'd0});
`endif
        at_edge(acc + 20);

        // Asynchronous reset mid-sweep
        expected = 8'hD5;
        start_sweep(1'b0, acc);
        at_edge(acc + 7);
        chk("pre_rst_vec", 32'(vec_out), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vec_out", 32'(vec_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_minterms", 32'(minterms), 32'd0);
        chk("arst_match", 32'(match), 32'd0);
`ifdef TT_MISMATCH_STOP_EN
        chk("arst_fail", 32'(fail), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        at_edge(cyc + 3);
        start_sweep(1'b0, acc);
        q1.push_back('{8'hD5, 1'b1, acc + 16, 1'b0, 3'd0});
        at_edge(acc + 20);

        // Start ignored while busy; expected changes after capture; back-to-back restart
        expected = 8'hD5;
        start_sweep(1'b0, acc);
        q1.push_back('{8'hD5, 1'b1, acc + 16, 1'b0, 3'd0});
        at_edge(acc + 2);
        start = 1'b1;
        expected = 8'h00;
        at_edge(acc + 3);
        start = 1'b0;
        at_edge(acc + 8);
        start = 1'b1;
        at_edge(acc + 9);
        start = 1'b0;
        at_edge(acc + 10);
        chk("no_restart_vec", 32'(vec_out), 32'd5);
        at_edge(acc + 16);
        expected = 8'hD5;
        start = 1'b1;
        at_edge(acc + 17);
        chk("done_start_ignored", 32'(busy), 32'd0);
        at_edge(acc + 18);
        start = 1'b0;
        q1.push_back('{8'hD5, 1'b1, acc + 34, 1'b0, 3'd0});
        chk("restart_busy", 32'(busy), 32'd1);
        at_edge(acc + 38);

        // N_IN=2, SETTLE_CYC=3, f = a & b
        expected2 = 4'h8;
        start_sweep(1'b1, acc2);
        q2.push_back('{8'h08, 1'b1, acc2 + 16, 1'b0, 3'd0});
        for (int k = 0; k <= 16; k += 2) begin
            at_edge(acc2 + k);
            chk("vec2_step", 32'(vec2), (k / 4 > 3) ? 32'd3 : 32'(k / 4));
        end
        at_edge(acc2 + 20);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
